// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Sits directly behind the 16-bit add/sub unit. It captures each adder
//   result into a 2-entry FIFO that feeds register writeback. It also keeps
//   the {N,Z,C,V} flag register and a saturating overflow-event counter.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (adder result)
//   in_s, in_cout,      adder sum, carry-out, overflow, and the Cin used
//   in_ov, in_sub         (1 = subtract)
//   in_setf             this op updates the flags
//   in_rd               destination register index
//   out_valid/out_ready downstream handshake (writeback)
//   out_data, out_rd    head entry of the FIFO
//   flags               {N,Z,C,V}
//   ovf_clr             clears the overflow counter (wins over an increment)
//   ovf_count, ovf_sat  accepted results with Ov=1; ovf_sat high at all-ones
//
// Handshake: a transfer happens on a rising edge where valid && ready.
//   valid must not depend on ready. in_ready is derived only from rst and
//   the count register, and out_valid only from the count register. There
//   is no combinational path from in_* to out_*.
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int WIDTH     = 16,
  parameter int RD_W      = 3,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_s,
  input  logic                 in_cout,
  input  logic                 in_ov,
  input  logic                 in_sub,
  input  logic                 in_setf,
  input  logic [RD_W-1:0]      in_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [RD_W-1:0]      out_rd,
  output logic [3:0]           flags,
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic                 ovf_sat
);

  logic [1:0]           count;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [WIDTH-1:0]     data_mem [2];
  logic [RD_W-1:0]      rd_mem   [2];
  logic                 push;
  logic                 pop;
  logic [OVF_CNT_W-1:0] ovf_next;
  logic [3:0]           flags_next;

  assign in_ready  = !rst && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry. The storage is reset so that out_data/out_rd read zero
  // after reset.
  assign out_data = data_mem[rd_ptr];
  assign out_rd   = rd_mem[rd_ptr];

  // FIFO storage, pointers and occupancy. The pointers are 1 bit wide, so
  // they wrap 1 -> 0 on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      data_mem[0] <= '0;
      data_mem[1] <= '0;
      rd_mem[0]   <= '0;
      rd_mem[1]   <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= in_s;
        rd_mem[wr_ptr]   <= in_rd;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The flag register updates only on a push that requests it. C reports a
  // borrow on subtract, so it is the inverse of the adder carry-out there.
  always_comb begin
    flags_next = flags;
    if (push && in_setf) begin
      flags_next = {in_s[WIDTH-1], (in_s == '0), (in_sub ? ~in_cout : in_cout), in_ov};
    end
  end

  // The overflow counter saturates and never wraps. A clear takes priority
  // over a same-cycle increment.
  always_comb begin
    ovf_next = ovf_count;
    if (ovf_clr) begin
      ovf_next = '0;
    end else if (push && in_ov && (ovf_count != {OVF_CNT_W{1'b1}})) begin
      ovf_next = ovf_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags     <= 4'b0000;
      ovf_count <= '0;
      ovf_sat   <= 1'b0;
    end else begin
      flags     <= flags_next;
      ovf_count <= ovf_next;
      ovf_sat   <= (ovf_next == {OVF_CNT_W{1'b1}});
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//   Runs directed scenarios and then randomized traffic against
//   alu_result_stage. A behavioural model is kept alongside the DUT: a queue
//   of pending {rd,data} entries, a flag value and a saturating integer
//   counter. The DUT outputs are compared to that model on every cycle, and
//   directed constant checks cover the listed scenarios.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

  localparam int WIDTH     = 16;
  localparam int RD_W      = 3;
  localparam int OVF_CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_s;
  logic                 in_cout;
  logic                 in_ov;
  logic                 in_sub;
  logic                 in_setf;
  logic [RD_W-1:0]      in_rd;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [RD_W-1:0]      out_rd;
  logic [3:0]           flags;
  logic                 ovf_clr;
  logic [OVF_CNT_W-1:0] ovf_count;
  logic                 ovf_sat;

  alu_result_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .OVF_CNT_W(OVF_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_cout   (in_cout),
    .in_ov     (in_ov),
    .in_sub    (in_sub),
    .in_setf   (in_setf),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .flags     (flags),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count),
    .ovf_sat   (ovf_sat)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [WIDTH+RD_W-1:0] exp_q[$];   // {rd, data}, front = head
  logic [3:0]            exp_flags;
  int                    exp_ovf;
  int                    n_vec;
  int                    n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs with the model at the negedge. Then advance the
  // model across the next posedge, using the inputs currently driven.
  task automatic cycle();
    bit push;
    bit pop;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(!rst && exp_q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(exp_q[0][WIDTH-1:0]));
      check("out_rd", 32'(out_rd), 32'(exp_q[0][WIDTH+RD_W-1:WIDTH]));
    end
    check("flags", 32'(flags), 32'(exp_flags));
    check("ovf_count", 32'(ovf_count), 32'(exp_ovf));
    check("ovf_sat", 32'(ovf_sat), 32'(exp_ovf == 255));
    push = in_valid && !rst && (exp_q.size() < 2);
    pop  = out_ready && (exp_q.size() != 0);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_flags = 4'b0000;
      exp_ovf   = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({in_rd, in_s});
        if (in_setf)
          exp_flags = {in_s[WIDTH-1], in_s == 0, in_sub ? !in_cout : in_cout, in_ov};
      end
      if (ovf_clr) exp_ovf = 0;
      else if (push && in_ov && exp_ovf < 255) exp_ovf++;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [WIDTH-1:0] s, input logic co,
                       input logic ov, input logic sub, input logic setf,
                       input logic [RD_W-1:0] rd);
    in_valid = v; in_s = s; in_cout = co; in_ov = ov;
    in_sub = sub; in_setf = setf; in_rd = rd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0;
    exp_flags = 4'b0000; exp_ovf = 0;
    rst = 1'b1; out_ready = 1'b0; ovf_clr = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_rd", 32'(out_rd), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;

    // 1: single push, visible next cycle, gone one cycle later
    out_ready = 1'b1;
    drive(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    cycle();
    idle();
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data", 32'(out_data), 32'h0005);
    check("t1_rd", 32'(out_rd), 32'h2);
    cycle();
    check("t1_empty", 32'(out_valid), 32'h0);

    // 2: fill both entries, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    cycle();
    drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    cycle();
    idle();
    check("t2_full", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    check("t2_first", 32'(out_data), 32'h1111);
    cycle();
    check("t2_second", 32'(out_data), 32'h2222);
    cycle();
    check("t2_empty", 32'(out_valid), 32'h0);

    // 3: simultaneous push and pop at count=1
    out_ready = 1'b0;
    drive(1'b1, 16'h0AAA, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    cycle();
    out_ready = 1'b1;
    drive(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
    cycle();
    idle();
    check("t3_valid", 32'(out_valid), 32'h1);
    check("t3_head", 32'(out_data), 32'h3333);
    check("t3_ready", 32'(in_ready), 32'h1);
    drain();

    // 4: flag updates (Z with borrow clear, then N and V)
    drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    cycle();
    idle();
    check("t4_flags_z", 32'(flags), 32'h4);
    drive(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
    cycle();
    idle();
    check("t4_flags_nv", 32'(flags), 32'h9);
    drive(1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);  // setf=0: flags hold
    cycle();
    idle();
    check("t4_flags_hold", 32'(flags), 32'h9);
    drain();

    // 5: saturating overflow counter and clear priority
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 16'($urandom_range(0, 16'hFFFF)), 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
      cycle();
    end
    check("t5_cnt_ff", 32'(ovf_count), 32'hFF);
    check("t5_sat", 32'(ovf_sat), 32'h1);
    cycle();
    check("t5_cnt_hold", 32'(ovf_count), 32'hFF);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    idle();
    check("t5_clr", 32'(ovf_count), 32'h0);
    check("t5_sat_clr", 32'(ovf_sat), 32'h0);
    drain();

    // 6: reset with two entries queued
    out_ready = 1'b0;
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6);
    cycle();
    drive(1'b1, 16'hCAFE, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7);
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    check("t6_valid", 32'(out_valid), 32'h0);
    check("t6_flags", 32'(flags), 32'h0);
    rst = 1'b0;
    #1;
    check("t6_ready", 32'(in_ready), 32'h1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(0, 16'hFFFF)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)));
      out_ready = 1'($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; ovf_clr = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
